// File: rtl/norm_unit.sv
// Leading-zero / redundant-sign normalizer with an IDLE/SHIFT/DONE sequencer.
// Optional build macro NORM_EARLY_DONE_EN: exit SHIFT as soon as the value is normalized.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start
// SHIFT | shifting the working value left one bit per cycle (Busy)
// DONE  | result registered, Done pulses; Start may chain a new op

module norm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Norm_In,
  input  logic        Mode,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Norm_Out,
  output logic [3:0]  Norm_Cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] work_q, work_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        mode_q, mode_nxt;
  logic [15:0] res_q;
  logic [3:0]  res_cnt_q;
  logic        accept, normed, step, exit_shift, load_res;

  assign accept = Start && ((state == IDLE) || (state == DONE));
  assign normed = mode_q ? (work_q[15] ^ work_q[14]) : work_q[15];
  assign step   = !normed && (cnt_q != 4'd15);

`ifdef NORM_EARLY_DONE_EN
  assign exit_shift = !step;
`else
  // Fixed-latency build: a down-counter gives exactly 16 SHIFT cycles.
  logic [3:0] tmr_q;

  always_ff @(posedge clk) begin
    if (rst)
      tmr_q <= 4'd0;
    else if (accept)
      tmr_q <= 4'd15;
    else if ((state == SHIFT) && (tmr_q != 4'd0))
      tmr_q <= tmr_q - 4'd1;
  end

  assign exit_shift = (tmr_q == 4'd0);
`endif

  always_comb begin
    state_nxt = state;
    work_nxt  = work_q;
    cnt_nxt   = cnt_q;
    mode_nxt  = mode_q;
    load_res  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) state_nxt = IDLE;
        if (Start) begin
          state_nxt = SHIFT;
          work_nxt  = Norm_In;
          mode_nxt  = Mode;
          cnt_nxt   = 4'd0;
        end
      end
      SHIFT: begin
        if (step) begin
          work_nxt = {work_q[14:0], 1'b0};
          cnt_nxt  = cnt_q + 4'd1;
        end
        if (exit_shift) begin
          state_nxt = DONE;
          load_res  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work_q    <= 16'h0000;
      cnt_q     <= 4'd0;
      mode_q    <= 1'b0;
      res_q     <= 16'h0000;
      res_cnt_q <= 4'd0;
    end else begin
      state  <= state_nxt;
      work_q <= work_nxt;
      cnt_q  <= cnt_nxt;
      mode_q <= mode_nxt;
      if (load_res) begin
        res_q     <= work_nxt;
        res_cnt_q <= cnt_nxt;
      end
    end
  end

  assign Busy     = (state == SHIFT);
  assign Done     = (state == DONE);
  assign Norm_Out = res_q;
  assign Norm_Cnt = res_cnt_q;

endmodule

// File: tb/tb_norm_unit.sv
// Directed self-checking bench for norm_unit; expected latency follows NORM_EARLY_DONE_EN.
module tb_norm_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Norm_In = 16'h0000;
  logic        Mode = 1'b0;
  logic        Start = 1'b0;
  logic        Busy, Done;
  logic [15:0] Norm_Out;
  logic [3:0]  Norm_Cnt;

  int tests = 0;
  int fails = 0;

  norm_unit dut (
    .clk(clk), .rst(rst), .Norm_In(Norm_In), .Mode(Mode), .Start(Start),
    .Busy(Busy), .Done(Done), .Norm_Out(Norm_Out), .Norm_Cnt(Norm_Cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_for(input int cnt);
`ifdef NORM_EARLY_DONE_EN
    return cnt + 2;
`else
    return 17;
`endif
  endfunction

  // One operation; at cycle poke a stray Start with a different operand/mode is driven.
  task automatic run_op(input string tag, input logic [15:0] din, input logic md,
                        input logic [15:0] eo, input logic [3:0] ec, input int poke);
    logic [15:0] prev_out;
    logic [3:0]  prev_cnt;
    int cyc, busy_n, hold_ok, exp_lat;
    exp_lat  = lat_for(int'(ec));
    prev_out = Norm_Out;
    prev_cnt = Norm_Cnt;
    Start = 1'b1; Norm_In = din; Mode = md;
    step();
    Start = 1'b0;
    cyc = 1; busy_n = 0; hold_ok = 1;
    while (!Done && cyc < 40) begin
      if (Busy) busy_n++;
      if (Norm_Out !== prev_out || Norm_Cnt !== prev_cnt) hold_ok = 0;
      if (cyc == poke) begin
        Start = 1'b1; Norm_In = 16'h0F00; Mode = ~md;
      end else if (cyc == poke + 1) begin
        Start = 1'b0; Norm_In = din; Mode = md;
      end
      step();
      cyc++;
    end
    Start = 1'b0;
    chk({tag, " done_seen"}, 32'(Done), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    chk({tag, " out_held"}, 32'(hold_ok), 32'd1);
    chk({tag, " busy_in_done"}, 32'(Busy), 32'd0);
    chk({tag, " norm_out"}, 32'(Norm_Out), 32'(eo));
    chk({tag, " norm_cnt"}, 32'(Norm_Cnt), 32'(ec));
    step();
    chk({tag, " done_one_cycle"}, 32'(Done), 32'd0);
    chk({tag, " result_hold"}, 32'(Norm_Out), 32'(eo));
  endtask

  initial begin
    int cyc, done_seen;
    step(); step();
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst out", 32'(Norm_Out), 32'h0);
    chk("rst cnt", 32'(Norm_Cnt), 32'h0);
    rst = 1'b0;

    run_op("u_0001", 16'h0001, 1'b0, 16'h8000, 4'd15, 0);
    run_op("s_FFF0", 16'hFFF0, 1'b1, 16'h8000, 4'd11, 0);
    run_op("s_0123", 16'h0123, 1'b1, 16'h48C0, 4'd6, 0);
    run_op("s_4000", 16'h4000, 1'b1, 16'h4000, 4'd0, 0);
    run_op("u_0000", 16'h0000, 1'b0, 16'h0000, 4'd15, 0);
    run_op("s_0000", 16'h0000, 1'b1, 16'h0000, 4'd15, 0);
    run_op("u_0F00", 16'h0F00, 1'b0, 16'hF000, 4'd4, 0);
    run_op("s_FFFF", 16'hFFFF, 1'b1, 16'h8000, 4'd15, 0);
    run_op("s_0001", 16'h0001, 1'b1, 16'h4000, 4'd14, 0);
    run_op("u_8000", 16'h8000, 1'b0, 16'h8000, 4'd0, 0);
    run_op("ignore", 16'h0001, 1'b0, 16'h8000, 4'd15, 3);

    // Back-to-back: Start held high from acceptance through the DONE cycle.
    Start = 1'b1; Norm_In = 16'h0001; Mode = 1'b0;
    step();
    Norm_In = 16'h0123; Mode = 1'b1;
    cyc = 1;
    while (!Done && cyc < 40) begin step(); cyc++; end
    chk("b2b first latency", 32'(cyc), 32'd17);
    chk("b2b first out", 32'(Norm_Out), 32'h8000);
    chk("b2b first cnt", 32'(Norm_Cnt), 32'd15);
    step();
    Start = 1'b0;
    chk("b2b busy next", 32'(Busy), 32'd1);
    chk("b2b done gone", 32'(Done), 32'd0);
    chk("b2b out kept", 32'(Norm_Out), 32'h8000);
    cyc = 1;
    while (!Done && cyc < 40) begin step(); cyc++; end
    chk("b2b second latency", 32'(cyc), 32'(lat_for(6)));
    chk("b2b second out", 32'(Norm_Out), 32'h48C0);
    chk("b2b second cnt", 32'(Norm_Cnt), 32'd6);
    step();

    // Reset asserted in cycle 5 of an operation.
    Start = 1'b1; Norm_In = 16'h0001; Mode = 1'b0;
    step();
    Start = 1'b0;
    repeat (4) step();
    chk("abort busy before", 32'(Busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 32'(Busy), 32'd0);
    chk("abort done", 32'(Done), 32'd0);
    chk("abort out", 32'(Norm_Out), 32'h0);
    chk("abort cnt", 32'(Norm_Cnt), 32'h0);
    run_op("post_rst", 16'h0123, 1'b1, 16'h48C0, 4'd6, 0);

    // Reset again and confirm an idle block never pulses Done.
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      step();
      if (Done) done_seen = 1;
    end
    chk("abort no done", 32'(done_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/norm_unit.md
NORM_UNIT -- requirements
Module: norm_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
  - clk  input  1  rising-edge clock, sole clock domain.
  - rst  input  1  synchronous active-high reset.
  - Norm_In  input  16  operand to normalize; sampled only on an accepted Start.
  - Mode  input  1  0 = unsigned (leading zeros), 1 = signed (redundant sign bits); sampled with Norm_In.
  - Start  input  1  request pulse; sampled each cycle.
  - Busy  output  1  high while an operation is in progress.
  - Done  output  1  one-cycle completion pulse.
  - Norm_Out  output  16  normalized operand.
  - Norm_Cnt  output  4  left-shift count applied to Norm_In.

Function
REQ-002 The block SHALL have three states: IDLE, SHIFT and DONE.
REQ-003 Start SHALL be accepted in IDLE or DONE; on acceptance the block loads Norm_In and Mode into working registers, clears the count, and enters SHIFT on the next edge.
REQ-004 Start SHALL be ignored while in SHIFT, with no effect on operands or outputs.
REQ-005 Normalized SHALL mean bit15 == 1 in unsigned mode, and bit15 != bit14 in signed mode.
REQ-006 Each SHIFT cycle, if the working value is not normalized and the count is below 15, the block SHALL shift it left by 1 (zero fill) and increment the count by 1.
  - Otherwise the working value and count SHALL hold.
REQ-007 The count SHALL saturate at 15, giving Norm_Out = 0x0000 and Norm_Cnt = 15 for input 0x0000 in either mode.
REQ-008 Busy SHALL be high exactly during SHIFT cycles.
REQ-009 Done SHALL be high for exactly the one cycle spent in DONE; the state then returns to IDLE unless Start is accepted in that cycle.
REQ-010 Norm_Out and Norm_Cnt SHALL update when DONE is entered and SHALL hold until the next entry into DONE.
  - They SHALL NOT change during SHIFT.
REQ-011 Mode and the operand SHALL be held internally for the whole operation, so changes on Norm_In or Mode during SHIFT have no effect.
REQ-012 Results SHALL satisfy the following, per mode:
  - Signed: an arithmetic right shift of Norm_Out by Norm_Cnt equals Norm_In.
  - Unsigned: a logical right shift of Norm_Out by Norm_Cnt equals Norm_In, for Norm_In != 0.
REQ-013 Latency is counted with the Start-accepted cycle as cycle 0. In the base build, Done SHALL assert in cycle 17 for every operand, with 16 SHIFT cycles.
REQ-014 If Start is accepted in the DONE cycle, the next operation SHALL begin with no idle gap, and its own Done SHALL follow per REQ-013 or REQ-018.

Reset
REQ-015 On rst sampled high, the block SHALL enter IDLE, with Busy = 0, Done = 0, Norm_Out = 0x0000, Norm_Cnt = 0, working registers = 0.
REQ-016 Reset SHALL take priority over Start, including reset asserted mid-SHIFT; the aborted operation produces no Done.
REQ-017 In the cycle after rst deasserts, a Start SHALL be accepted normally.

Configuration
REQ-018 With macro NORM_EARLY_DONE_EN defined, SHIFT SHALL exit on the first cycle in which the working value is normalized or the count equals 15.
  - Done then asserts in cycle Norm_Cnt + 2: cycle 2 for an already-normalized input, cycle 17 at most.
  - Without the macro, the fixed latency of REQ-013 applies.
  - Result values SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Unsigned, Norm_In = 0x0001 -> Norm_Out = 0x8000, Norm_Cnt = 15, Done in cycle 17 in both builds.
  - Signed, Norm_In = 0xFFF0 -> Norm_Out = 0x8000, Norm_Cnt = 11; Done in cycle 13 with NORM_EARLY_DONE_EN, cycle 17 without.
  - Signed, Norm_In = 0x0123 -> Norm_Out = 0x48C0, Norm_Cnt = 6; signed, Norm_In = 0x4000 -> Norm_Cnt = 0, Done in cycle 2 with the macro.
  - Unsigned and signed, Norm_In = 0x0000 -> Norm_Out = 0x0000, Norm_Cnt = 15; Busy high for exactly the SHIFT cycles; Done high for one cycle.
  - Second Start with Norm_In = 0x0F00 during SHIFT of 0x0001 -> ignored, first result unchanged; Start held high through the DONE cycle -> back-to-back operation, Busy high in the following cycle.
  - rst asserted in cycle 5 of an operation -> Busy = 0, Done never pulses, Norm_Out = 0x0000, Norm_Cnt = 0; a Start on the next cycle completes correctly.
